writeback_stage: RTL

Y86-64 pipeline W-stage register and retirement controller. Captures the memory-stage result each cycle, holds it for one cycle as the W pipeline register, and drives the write port (dstE/E, dstM/M) of the register file. Tracks machine status (run/halt/error) and counts retired instructions. Sits between the memory stage and the register file.

---
 rtl/writeback_stage.sv | 127 ++++++++++++
 1 files changed

// File: rtl/writeback_stage.sv
// Y86-64 W pipeline register + retirement/status tracker; all outputs registered, 1-cycle latency.
// W_stall holds W (beats W_bubble); once HALT/ERR is entered the register freezes until reset.
module writeback_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        m_valid,
    input  logic [2:0]  m_stat,
    input  logic [3:0]  m_icode,
    input  logic [63:0] m_valE,
    input  logic [63:0] m_valM,
    input  logic [3:0]  m_dstE,
    input  logic [3:0]  m_dstM,
    input  logic        W_stall,
    input  logic        W_bubble,
    output logic [3:0]  dstE,
    output logic [63:0] E,
    output logic [3:0]  dstM,
    output logic [63:0] M,
    output logic        w_valid,
    output logic [2:0]  w_stat,
    output logic [3:0]  w_icode,
    output logic [1:0]  state,
    output logic [63:0] retired
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HALT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;
    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] I_NOP    = 4'h1;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_dstE;
    logic [63:0] r_E;
    logic [3:0]  r_dstM;
    logic [63:0] r_M;
    logic        r_valid;
    logic [2:0]  r_stat;
    logic [3:0]  r_icode;
    logic [63:0] r_retired;

    logic [2:0]  w_stat_norm;
    logic        w_run;
    logic        w_load;
    logic        w_load_bubble;
    logic        w_aok;

    // Unknown status codes are folded into INS so W never carries an illegal value.
    always_comb begin
        w_stat_norm = STAT_INS;
        case (m_stat)
            STAT_AOK, STAT_HLT, STAT_ADR: w_stat_norm = m_stat;
            default:                      w_stat_norm = STAT_INS;
        endcase
    end

    assign w_run         = (r_state == S_RUN);
    assign w_load        = w_run && !W_stall && !W_bubble && m_valid;
    assign w_load_bubble = w_run && !W_stall && (W_bubble || !m_valid);
    assign w_aok         = (w_stat_norm == STAT_AOK);

    always_comb begin
        w_state_nxt = r_state;
        if (w_load) begin
            if (w_stat_norm == STAT_HLT) begin
                w_state_nxt = S_HALT;
            end else if (!w_aok) begin
                w_state_nxt = S_ERR;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || w_load_bubble) begin
            r_valid <= 1'b0;
            r_stat  <= STAT_AOK;
            r_icode <= I_NOP;
            r_dstE  <= REG_NONE;
            r_dstM  <= REG_NONE;
            r_E     <= 64'd0;
            r_M     <= 64'd0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_stat  <= w_stat_norm;
            r_icode <= m_icode;
            r_dstE  <= w_aok ? m_dstE : REG_NONE;
            r_dstM  <= w_aok ? m_dstM : REG_NONE;
            r_E     <= m_valE;
            r_M     <= m_valM;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_retired <= 64'd0;
        end else if (w_load && w_aok) begin
            r_retired <= r_retired + 64'd1;
        end
    end

    assign dstE    = r_dstE;
    assign E       = r_E;
    assign dstM    = r_dstM;
    assign M       = r_M;
    assign w_valid = r_valid;
    assign w_stat  = r_stat;
    assign w_icode = r_icode;
    assign state   = r_state;
    assign retired = r_retired;

endmodule
